param_bus_processor: RTL and testbench

- Multicycle 8-register bus processor, generalised to DATA_W-bit data.
- Has a run/done handshake and a 3-bit opcode covering mv, mvi, add, sub, and, or, xor, mvnz.
- All transfers go over a single shared bus, buswires, exported for debug together with r0/r1.
- Top-level compute core of the lab datapath; instruction/immediate words come from din.

---
 rtl/param_bus_processor.sv | 139 +++++++++++++
 tb/tb_param_bus_processor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/param_bus_processor.sv
// Multicycle 8-register bus processor. Every transfer goes over a single
// shared bus; ALU instructions take three execute cycles (T1..T3), moves
// take one. Handshake: run is sampled only in T0, and done is high for
// exactly one cycle, the final cycle of each instruction.
module param_bus_processor #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [DATA_W-1:0] din,
   output logic              done,
   output logic [DATA_W-1:0] buswires,
   output logic [DATA_W-1:0] r0,
   output logic [DATA_W-1:0] r1,
   output logic              zflag
);

   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MVNZ = 3'b111;

   state_t            state, state_nxt;
   logic [8:0]        ir;
   logic [DATA_W-1:0] regs [0:7];
   logic [DATA_W-1:0] a_reg, g_reg;
   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] alu_res;
   logic              ir_ld, a_ld, g_ld, z_ld, wr_en;

   wire [2:0] op = ir[8:6];
   wire [2:0] rx = ir[5:3];
   wire [2:0] ry = ir[2:0];

   assign buswires = bus;
   assign r0       = regs[0];
   assign r1       = regs[1];

   // State register, register file, A/G/IR and zero flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= T0;
         ir    <= '0;
         a_reg <= '0;
         g_reg <= '0;
         zflag <= 1'b1;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         if (ir_ld) ir    <= din[8:0];
         if (a_ld)  a_reg <= bus;
         if (g_ld)  g_reg <= alu_res;
         if (z_ld)  zflag <= (g_reg == '0);
         // Every register write takes its data from the bus.
         if (wr_en) regs[rx] <= bus;
      end
   end

   // ALU: A is the left operand, the bus (Rry in T2) the right one.
   always_comb begin
      alu_res = a_reg + bus;
      case (op)
         OP_ADD:  alu_res = a_reg + bus;
         OP_SUB:  alu_res = a_reg - bus;
         OP_AND:  alu_res = a_reg & bus;
         OP_OR:   alu_res = a_reg | bus;
         OP_XOR:  alu_res = a_reg ^ bus;
         default: alu_res = a_reg + bus;
      endcase
   end

   // Next-state, bus driver select and control strobes.
   always_comb begin
      state_nxt = state;
      bus       = '0;
      done      = 1'b0;
      ir_ld     = 1'b0;
      a_ld      = 1'b0;
      g_ld      = 1'b0;
      z_ld      = 1'b0;
      wr_en     = 1'b0;
      case (state)
         T0: begin
            if (run) begin
               ir_ld     = 1'b1;
               state_nxt = T1;
            end
         end
         T1: begin
            case (op)
               OP_MV: begin
                  bus       = regs[ry];
                  wr_en     = 1'b1;
                  done      = 1'b1;
                  state_nxt = T0;
               end
               OP_MVI: begin
                  bus       = din;
                  wr_en     = 1'b1;
                  done      = 1'b1;
                  state_nxt = T0;
               end
               OP_MVNZ: begin
                  bus       = regs[ry];
                  wr_en     = ~zflag;
                  done      = 1'b1;
                  state_nxt = T0;
               end
               default: begin
                  bus       = regs[rx];
                  a_ld      = 1'b1;
                  state_nxt = T2;
               end
            endcase
         end
         T2: begin
            bus       = regs[ry];
            g_ld      = 1'b1;
            state_nxt = T3;
         end
         T3: begin
            bus       = g_reg;
            wr_en     = 1'b1;
            z_ld      = 1'b1;
            done      = 1'b1;
            state_nxt = T0;
         end
         default: state_nxt = T0;
      endcase
   end

endmodule

// File: tb/tb_param_bus_processor.sv
// Directed bench for param_bus_processor (DATA_W=16). Inputs change 1ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_param_bus_processor;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         run = 1'b0;
   logic [W-1:0] din = '0;
   logic         done;
   logic [W-1:0] buswires, r0, r1;
   logic         zflag;

   int checks = 0;
   int errors = 0;

   param_bus_processor #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst), .run(run), .din(din), .done(done),
      .buswires(buswires), .r0(r0), .r1(r1), .zflag(zflag)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
      return {{(W-9){1'b0}}, op, rx, ry};
   endfunction

   // Fetch cycle: checks the idle T0 outputs, leaves the DUT in T1.
   task automatic issue(input logic [W-1:0] word);
      run = 1'b1;
      din = word;
      @(negedge clk);
      check_val("t0_done", {31'b0, done}, 32'd0);
      check_val("t0_bus", {16'b0, buswires}, 32'd0);
      step();
      run = 1'b0;
      din = '0;
   endtask

   task automatic do_mvi(input logic [2:0] rx, input logic [W-1:0] imm);
      issue(instr(3'b001, rx, 3'd0));
      din = imm;
      @(negedge clk);
      check_val("mvi_bus", {16'b0, buswires}, {16'b0, imm});
      check_val("mvi_done", {31'b0, done}, 32'd1);
      step();
      din = '0;
   endtask

   // mv / mvnz: single execute cycle.
   task automatic do_move(input logic [W-1:0] word, input logic [W-1:0] b1);
      issue(word);
      @(negedge clk);
      check_val("mv_bus", {16'b0, buswires}, {16'b0, b1});
      check_val("mv_done", {31'b0, done}, 32'd1);
      step();
   endtask

   task automatic do_alu(input logic [W-1:0] word, input logic [W-1:0] b1,
                         input logic [W-1:0] b2, input logic [W-1:0] b3);
      issue(word);
      @(negedge clk);
      check_val("t1_bus", {16'b0, buswires}, {16'b0, b1});
      check_val("t1_done", {31'b0, done}, 32'd0);
      step();
      @(negedge clk);
      check_val("t2_bus", {16'b0, buswires}, {16'b0, b2});
      check_val("t2_done", {31'b0, done}, 32'd0);
      step();
      @(negedge clk);
      check_val("t3_bus", {16'b0, buswires}, {16'b0, b3});
      check_val("t3_done", {31'b0, done}, 32'd1);
      step();
   endtask

   task automatic check_regs(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1, input logic ez);
      @(negedge clk);
      check_val({tag, "_r0"}, {16'b0, r0}, {16'b0, e0});
      check_val({tag, "_r1"}, {16'b0, r1}, {16'b0, e1});
      check_val({tag, "_z"}, {31'b0, zflag}, {31'b0, ez});
      step();
   endtask

   initial begin
      // 1. reset, then idle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("idle_done", {31'b0, done}, 32'd0);
         check_val("idle_bus", {16'b0, buswires}, 32'd0);
         step();
      end
      check_regs("reset", 16'h0, 16'h0, 1'b1);

      // 2. mvi r0,#5 (upper instruction bits set must be ignored)
      issue(16'hFE00 | instr(3'b001, 3'd0, 3'd0));
      din = 16'd5;
      @(negedge clk);
      check_val("mvi5_bus", {16'b0, buswires}, 32'd5);
      check_val("mvi5_done", {31'b0, done}, 32'd1);
      step();
      din = '0;
      check_regs("mvi5", 16'd5, 16'h0, 1'b1);

      // 3. mvi r1,#7; add r0,r1
      do_mvi(3'd1, 16'd7);
      do_alu(instr(3'b010, 3'd0, 3'd1), 16'd5, 16'd7, 16'd12);
      check_regs("add", 16'd12, 16'd7, 1'b0);

      // 4. sub r0,r0; mvnz blocked; then mvnz taken
      do_alu(instr(3'b011, 3'd0, 3'd0), 16'd12, 16'd12, 16'd0);
      check_regs("sub", 16'd0, 16'd7, 1'b1);
      do_move(instr(3'b111, 3'd1, 3'd0), 16'd0);
      check_regs("mvnz_z1", 16'd0, 16'd7, 1'b1);
      do_mvi(3'd0, 16'd3);
      do_alu(instr(3'b010, 3'd0, 3'd1), 16'd3, 16'd7, 16'd10);
      check_regs("add2", 16'd10, 16'd7, 1'b0);
      do_move(instr(3'b111, 3'd1, 3'd0), 16'd10);
      check_regs("mvnz_z0", 16'd10, 16'd10, 1'b0);

      // 5. wrap and logic
      do_mvi(3'd0, 16'hFFFF);
      do_mvi(3'd1, 16'h0001);
      do_alu(instr(3'b010, 3'd0, 3'd1), 16'hFFFF, 16'h0001, 16'h0000);
      check_regs("wrap", 16'h0000, 16'h0001, 1'b1);
      do_mvi(3'd0, 16'h00F0);
      do_mvi(3'd1, 16'h0FF0);
      do_alu(instr(3'b110, 3'd0, 3'd1), 16'h00F0, 16'h0FF0, 16'h0F00);
      check_regs("xor", 16'h0F00, 16'h0FF0, 1'b0);
      do_alu(instr(3'b100, 3'd0, 3'd1), 16'h0F00, 16'h0FF0, 16'h0F00);
      check_regs("and", 16'h0F00, 16'h0FF0, 1'b0);
      do_move(instr(3'b000, 3'd1, 3'd0), 16'h0F00);
      check_regs("mv", 16'h0F00, 16'h0F00, 1'b0);
      do_mvi(3'd0, 16'h00FF);
      do_alu(instr(3'b101, 3'd1, 3'd0), 16'h0F00, 16'h00FF, 16'h0FFF);
      check_regs("or", 16'h00FF, 16'h0FFF, 1'b0);
      do_alu(instr(3'b010, 3'd1, 3'd1), 16'h0FFF, 16'h0FFF, 16'h1FFE);
      check_regs("double", 16'h00FF, 16'h1FFE, 1'b0);
      do_alu(instr(3'b011, 3'd0, 3'd1), 16'h00FF, 16'h1FFE, 16'hE101);
      check_regs("sub_neg", 16'hE101, 16'h1FFE, 1'b0);

      // 6. reset during T2 of add r0,r1
      do_mvi(3'd0, 16'd5);
      do_mvi(3'd1, 16'd7);
      issue(instr(3'b010, 3'd0, 3'd1));
      @(negedge clk);
      check_val("abort_t1_bus", {16'b0, buswires}, 32'd5);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_val("abort_done", {31'b0, done}, 32'd0);
      check_val("abort_bus", {16'b0, buswires}, 32'd0);
      step();
      check_regs("abort", 16'h0, 16'h0, 1'b1);
      check_regs("abort_idle", 16'h0, 16'h0, 1'b1);
      do_mvi(3'd1, 16'd9);
      check_regs("after_abort", 16'h0, 16'd9, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
